// File: rtl/ets_phase_sweeper_pkg.sv
// ets_pkg: shared types for the ETS phase sweeper.
// FSM state enum, result-word layout, sizing helper.
package ets_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_EMIT,
    S_SHIFT,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_IDX_W = 16;
  // res_data = {step_idx, hit_cnt}
  localparam int IDX_LSB = DEF_CNT_W;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 2 : m;
  endfunction

endpackage

// File: rtl/ets_phase_sweeper_if.sv
// Result stream: res_data/res_valid/res_ready.
// master = sweeper, slave = MCU/GTH packer.
interface ets_phase_sweeper_if #(
  parameter int W = 32
) ();
  logic [W-1:0] res_data;
  logic         res_valid;
  logic         res_ready;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/ets_phase_sweeper_hit_counter.sv
// ets_hit_counter: 2-flop sync of cmp_data plus a
// saturating hit counter (clr wins over en).
module ets_hit_counter #(
  parameter int CNT_W = 16
) (
  input  logic             free_run_clk,
  input  logic             free_run_rst_n,
  input  logic             cmp_data,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [1:0] sync_q;

  always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
    if (!free_run_rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], cmp_data};
      if (clr)
        cnt <= '0;
      else if (en && sync_q[1] && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ets_phase_sweeper.sv
// ets_phase_sweeper: steps MMCM phase via ps_en/ps_done, counts
// comparator hits per step, streams {idx,cnt} words on res.
module ets_phase_sweeper
  import ets_pkg::*;
#(
  parameter int STEPS         = 448,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int DONE_TIMEOUT  = 1024,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int IDX_W         = DEF_IDX_W
) (
  input  logic free_run_clk,
  input  logic free_run_rst_n,
  input  logic start,
  input  logic abort,
  input  logic cmp_data,
  output logic ps_en,
  output logic ps_incdec,
  input  logic ps_done,
  ets_phase_sweeper_if.master res,
  output logic busy,
  output logic done,
  output logic err_timeout
);

  localparam int TMR_W =
    $clog2(max3(SETTLE_CYCLES, WINDOW_CYCLES, DONE_TIMEOUT));
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [IDX_W-1:0] idx_q;
  logic             abort_q;
  logic             pend_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_en;

  assign cnt_clr   = (state_q == S_SETTLE);
  assign cnt_en    = (state_q == S_ACCUM);
  assign ps_incdec = 1'b1;
  assign res.res_valid = valid_q;
  assign res.res_data  = {idx_q, cnt};

  ets_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit (
    .free_run_clk   (free_run_clk),
    .free_run_rst_n (free_run_rst_n),
    .cmp_data       (cmp_data),
    .clr            (cnt_clr),
    .en             (cnt_en),
    .cnt            (cnt)
  );

  // pend_q tracks an issued shift whose ps_done has not arrived
  // (e.g. abort right after ps_en); SHIFT holds off until it clears.
  always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
    if (!free_run_rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      abort_q     <= 1'b0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      ps_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ps_en <= 1'b0;
      done  <= 1'b0;
      if (ps_en)
        pend_q <= 1'b1;
      else if (ps_done || state_q == S_ERR)
        pend_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_q     <= S_SETTLE;
            tmr_q       <= '0;
            idx_q       <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (tmr_q == SET_LAST) begin
            state_q <= S_ACCUM;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_ACCUM: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (tmr_q == WIN_LAST) begin
            state_q <= S_EMIT;
            valid_q <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end else if (res.res_ready) begin
            state_q <= S_SHIFT;
            valid_q <= 1'b0;
            ps_en   <= !pend_q;
            tmr_q   <= '0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (ps_en) begin
            state_q <= S_WAIT;
            tmr_q   <= '0;
          end else if (!pend_q) begin
            ps_en <= 1'b1;
          end else if (tmr_q == TO_LAST) begin
            state_q     <= S_ERR;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (ps_done) begin
            abort_q <= 1'b0;
            if (abort_q || abort) begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end else if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= S_SETTLE;
              idx_q   <= idx_q + 1'b1;
              tmr_q   <= '0;
            end
          end else if (tmr_q == TO_LAST) begin
            abort_q     <= 1'b0;
            state_q     <= S_ERR;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
            if (abort)
              abort_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ets_phase_sweeper.md
# ets_phase_sweeper

Equivalent-time-sampling sweep controller sitting directly upstream of the ETS front end's MMCM dynamic phase-shift port. It steps the shifting clock's phase through one full sweep using the ps_en/ps_done handshake. At each phase step it counts comparator hits over a fixed window and streams one 32-bit result word per step to the MCU/GTH packing path. The MMCM ps_clk port is tied to free_run_clk at top level, so the whole block runs on one clock.

## Interface
- STEPS, 448: phase steps per sweep; one full shifting-clock period, so the phase returns to its start after a sweep.
- SETTLE_CYCLES, 16: wait after each shift before counting.
- WINDOW_CYCLES, 1024: counting window per step.
- DONE_TIMEOUT, 1024: maximum wait for ps_done.
- CNT_W, 16: hit-counter width; IDX_W, 16: step-index width. CNT_W+IDX_W = 32.

Ports:
- free_run_clk  in  1  sole clock.
- free_run_rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse; begins a sweep if idle.
- abort  in  1  one-cycle pulse; terminates the sweep.
- cmp_data  in  1  comparator bit, asynchronous to this clock.
- ps_en  out  1  one-cycle phase-shift request.
- ps_incdec  out  1  fixed 1 (increment).
- ps_done  in  1  MMCM shift-complete pulse.
- res_data  out  32  {step_idx[IDX_W-1:0], hit_cnt[CNT_W-1:0]}.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts.
- busy  out  1  high whenever not IDLE/ERR.
- done  out  1  one-cycle pulse at sweep completion.
- err_timeout  out  1  sticky timeout flag.

## Operation
- cmp_data passes through a 2-flop synchronizer. Only the synchronized bit is counted.
- Reset values: all outputs 0, except ps_incdec = 1. FSM starts in IDLE; step index and counter are 0.
- FSM states:
  - IDLE: start -> SETTLE, with idx=0 and err_timeout cleared.
  - SETTLE: SETTLE_CYCLES cycles -> ACCUM, with the counter cleared.
  - ACCUM: WINDOW_CYCLES cycles, adding the synchronized bit each cycle. The counter saturates at 2^CNT_W-1. -> EMIT.
  - EMIT: res_valid=1 and res_data held stable until res_ready. On handshake -> SHIFT.
  - SHIFT: ps_en=1 for exactly one cycle -> WAIT_DONE.
  - WAIT_DONE: on ps_done, if idx == STEPS-1 -> DONE, else idx+1 -> SETTLE. After DONE_TIMEOUT cycles without ps_done -> ERR.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: err_timeout=1; start -> SETTLE.
- Each sweep issues exactly STEPS shifts, including a final shift after the last emit, so cumulative phase returns to its start.
- start while busy: ignored.
- ps_done outside WAIT_DONE: ignored.
- abort in SETTLE/ACCUM/EMIT/SHIFT -> IDLE next cycle. res_valid drops immediately. A ps_en already issued in SHIFT is not cancelled; it is counted as an outstanding shift.
- abort in WAIT_DONE is latched and taken on ps_done or timeout, going to IDLE (or ERR on timeout). A second ps_en is never issued before the prior ps_done.
- abort and start in the same cycle while IDLE: start wins.

## Timing
- start at cycle t -> SETTLE at t+1.
- ACCUM spans t+1+SETTLE_CYCLES through t+SETTLE_CYCLES+WINDOW_CYCLES.
- First res_valid at t+1+SETTLE_CYCLES+WINDOW_CYCLES.
- ps_en occurs one cycle after the res handshake cycle.
- ps_done seen at cycle d -> SETTLE at d+1.
- Timeout: ERR is entered DONE_TIMEOUT cycles after entering WAIT_DONE.
- Synchronizer latency is 2 cycles. The window counts the synchronized values present during ACCUM cycles; no compensation is applied.
- All outputs are registered.

## Structure
- Shared package ets_pkg: FSM state enum, and a result-word field-layout constant (IDX_LSB = CNT_W).
- One sub-module, ets_hit_counter (synchronizer plus saturating counter with clear/enable). The FSM lives in the top.

## Test plan
Parameters for scenarios 1–5: STEPS=4, SETTLE_CYCLES=4, WINDOW_CYCLES=8. Scenario 6 uses WINDOW_CYCLES=16 and CNT_W=3.
1. cmp_data=1, ps_done 3 cycles after each ps_en, res_ready=1 -> words 0x00000008, 0x00010008, 0x00020008, 0x00030008; exactly 4 ps_en pulses; one done pulse; busy=0 after.
2. cmp_data=0 -> four words with count 0. cmp_data toggling every cycle -> counts 4 (±1 for synchronizer phase).
3. res_ready low for 20 cycles at step 1 -> res_valid high and res_data=0x00010008 stable throughout; no ps_en until the handshake.
4. ps_done never returned -> ERR exactly 1024 cycles after WAIT_DONE entry; err_timeout=1, busy=0. Next start clears err_timeout.
5. abort mid-ACCUM -> busy=0 next cycle, no further words. abort in WAIT_DONE -> stays until ps_done, then IDLE, with no extra ps_en.
6. start pulsed while busy and spurious ps_done in SETTLE -> no effect on sequence. WINDOW_CYCLES=16 with CNT_W=3 -> count saturates at 7.
